// File: rtl/fifo8x9_ctrl.sv
// fifo8x9_ctrl: req/ack handshake controller sequencing the strobes of an 8x9 FIFO storage array.
// Define FIFO8X9_CTRL_ERR_EN to build the sticky overflow/underflow error flags.
module fifo8x9_ctrl #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_req,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ack,
    input  logic                  pop_req,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  wren,
    output logic                  rden,
    output logic                  WrInc,
    output logic                  RdInc,
    output logic                  WrPtrClr,
    output logic                  RdPtrClr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err_ovf,
    output logic                  err_unf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        WR   = 6'b000010,
        WINC = 6'b000100,
        RD   = 6'b001000,
        RINC = 6'b010000,
        CLR  = 6'b100000
    } state_t;

    state_t state;
    logic   last_wr;
    logic   pend_clr;
    logic   can_push;
    logic   can_pop;

    assign full     = count == (ADDR_WIDTH + 1)'(DEPTH);
    assign empty    = count == '0;
    assign can_push = push_req & ~full;
    assign can_pop  = pop_req & ~empty;

    // Strobes decode purely from state flops so the storage sees glitch-free pointer clocks.
    assign wren      = state == WR;
    assign WrInc     = state == WINC;
    assign push_ack  = state == WINC;
    assign rden      = state == RD;
    assign RdInc     = state == RINC;
    assign pop_valid = state == RINC;
    assign WrPtrClr  = state == CLR;
    assign RdPtrClr  = state == CLR;
    assign pop_data  = fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            fifo_din <= '0;
            last_wr  <= 1'b0;
            pend_clr <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_clr | clr) begin
                        state <= CLR;
                    end else if (can_push && !(can_pop && last_wr)) begin
                        state    <= WR;
                        fifo_din <= push_data;
                    end else if (can_pop) begin
                        state <= RD;
                    end
                end
                WR:   state <= WINC;
                WINC: begin
                    state   <= IDLE;
                    count   <= count + (ADDR_WIDTH + 1)'(1);
                    last_wr <= 1'b1;
                end
                RD:   state <= RINC;
                RINC: begin
                    state   <= IDLE;
                    count   <= count - (ADDR_WIDTH + 1)'(1);
                    last_wr <= 1'b0;
                end
                CLR: begin
                    state    <= IDLE;
                    count    <= '0;
                    pend_clr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO8X9_CTRL_ERR_EN
    // Flags clear on the same IDLE cycle that commits to CLR.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (state == IDLE) begin
            err_ovf <= (pend_clr | clr) ? 1'b0 : err_ovf | (push_req & full);
            err_unf <= (pend_clr | clr) ? 1'b0 : err_unf | (pop_req & empty);
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif
endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// tb_fifo8x9_ctrl: scoreboard bench for fifo8x9_ctrl with a behavioural 8x9 storage array.
module tb_fifo8x9_ctrl;
`ifdef FIFO8X9_CTRL_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst, push_req, pop_req, clr;
    logic [8:0] push_data, pop_data, fifo_din;
    logic [8:0] fifo_dout = '0;
    logic push_ack, pop_valid, wren, rden, WrInc, RdInc, WrPtrClr, RdPtrClr;
    logic full, empty, err_ovf, err_unf;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;
    logic [8:0] wq[$];
    logic [8:0] rq[$];

    fifo8x9_ctrl dut (
        .clk(clk), .rst(rst), .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
        .pop_req(pop_req), .pop_data(pop_data), .pop_valid(pop_valid), .clr(clr),
        .fifo_din(fifo_din), .fifo_dout(fifo_dout), .wren(wren), .rden(rden),
        .WrInc(WrInc), .RdInc(RdInc), .WrPtrClr(WrPtrClr), .RdPtrClr(RdPtrClr),
        .full(full), .empty(empty), .count(count), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    // Storage array: write/read at end of wren/rden cycles, pointers step on the inc strobes.
    logic [8:0] mem[8];
    logic [2:0] wp = '0;
    logic [2:0] rp = '0;
    always @(posedge clk) begin
        if (wren) mem[wp] <= fifo_din;
        if (rden) fifo_dout <= mem[rp];
        if (WrPtrClr) wp <= '0; else if (WrInc) wp <= wp + 3'd1;
        if (RdPtrClr) rp <= '0; else if (RdInc) rp <= rp + 3'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wren) begin
            if (wq.size() == 0) chk("wren_unexpected", 1, 0);
            else chk("fifo_din", int'(fifo_din), int'(wq.pop_front()));
        end
        if (pop_valid) begin
            if (rq.size() == 0) chk("pop_valid_unexpected", 1, 0);
            else chk("pop_data", int'(pop_data), int'(rq.pop_front()));
        end
    end

    task automatic do_push(input logic [8:0] d);
        int n = 0;
        wq.push_back(d);
        push_req = 1'b1;
        push_data = d;
        do begin @(negedge clk); n++; end while (!push_ack && n < 20);
        chk("push_ack", int'(push_ack), 1);
        chk("push_lat", n, 2);
        chk("wrinc_with_ack", int'(WrInc), 1);
        push_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_pop(input logic [8:0] e);
        int n = 0;
        rq.push_back(e);
        pop_req = 1'b1;
        do begin @(negedge clk); n++; end while (!pop_valid && n < 20);
        chk("pop_valid", int'(pop_valid), 1);
        chk("pop_lat", n, 2);
        chk("rdinc_with_valid", int'(RdInc), 1);
        pop_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_strobes", int'({wren, rden, WrInc, RdInc, WrPtrClr, RdPtrClr, push_ack, pop_valid}), 0);
        end
        rst = 1'b0;
        chk("rel1_ptrclr", int'(WrPtrClr | RdPtrClr), 0);
        @(negedge clk);
        chk("rel2_wrptrclr", int'(WrPtrClr), 1);
        chk("rel2_rdptrclr", int'(RdPtrClr), 1);
        @(negedge clk);
        chk("rel3_ptrclr", int'(WrPtrClr | RdPtrClr), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
    endtask

    initial begin
        int n;
        int nw;
        int nr;
        bit exp_w;
        push_req = 1'b0; pop_req = 1'b0; clr = 1'b0; push_data = '0;
        do_reset();
        chk("rst_err_ovf", int'(err_ovf), 0);

        do_push(9'h1A5);
        chk("single_count", int'(count), 1);
        chk("single_empty", int'(empty), 0);
        do_pop(9'h1A5);
        chk("single_pop_count", int'(count), 0);

        for (int i = 0; i < 8; i++) do_push(9'(9'h100 + i));
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 8);

        push_req = 1'b1; push_data = 9'h1FF; n = 0;
        repeat (10) begin @(negedge clk); n += int'(wren | push_ack); end
        chk("ovf_no_write", n, 0);
        chk("err_ovf", int'(err_ovf), ERR_EN);
        push_req = 1'b0;

        for (int i = 0; i < 8; i++) do_pop(9'(9'h100 + i));
        chk("drain_empty", int'(empty), 1);
        chk("drain_count", int'(count), 0);

        pop_req = 1'b1; n = 0;
        repeat (10) begin @(negedge clk); n += int'(rden | pop_valid); end
        chk("unf_no_read", n, 0);
        chk("err_unf", int'(err_unf), ERR_EN);
        chk("err_ovf_sticky", int'(err_ovf), ERR_EN);
        pop_req = 1'b0;

        for (int i = 0; i < 3; i++) do_push(9'(9'h050 + i));
        chk("pre_clr_count", int'(count), 3);
        wq.push_back(9'h030);
        push_req = 1'b1; push_data = 9'h030; n = 0;
        do begin @(negedge clk); n++; end while (!wren && n < 20);
        chk("clr_wr_seen", int'(wren), 1);
        clr = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!push_ack && n < 20);
        chk("clr_push_ack", int'(push_ack), 1);
        push_req = 1'b0;
        @(negedge clk);
        chk("clr_count4", int'(count), 4);
        @(negedge clk);
        chk("clr_wrptrclr", int'(WrPtrClr), 1);
        chk("clr_rdptrclr", int'(RdPtrClr), 1);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_one_cycle", int'(WrPtrClr), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_err_ovf", int'(err_ovf), 0);
        chk("clr_err_unf", int'(err_unf), 0);

        do_reset();
        for (int i = 0; i < 4; i++) do_push(9'(9'h010 + i));
        do_pop(9'h010);
        chk("cont_start_count", int'(count), 3);
        rq.push_back(9'h011); rq.push_back(9'h012); rq.push_back(9'h013);
        wq.push_back(9'h020); wq.push_back(9'h021); wq.push_back(9'h022);
        push_req = 1'b1; push_data = 9'h020; pop_req = 1'b1;
        nw = 0; nr = 0; exp_w = 1'b1;
        for (int c = 0; c < 60 && (nw < 3 || nr < 3); c++) begin
            @(negedge clk);
            if (wren) begin chk("alt_write", int'(exp_w), 1); exp_w = 1'b0; end
            if (rden) begin chk("alt_read", int'(exp_w), 0); exp_w = 1'b1; end
            chk("cont_count_range", int'(count == 4'd3 || count == 4'd4), 1);
            if (push_ack) begin
                nw++;
                push_data = 9'(9'h020 + nw);
                if (nw == 3) push_req = 1'b0;
            end
            if (pop_valid) begin
                nr++;
                if (nr == 3) pop_req = 1'b0;
            end
        end
        chk("cont_writes", nw, 3);
        chk("cont_reads", nr, 3);
        repeat (3) @(negedge clk);
        chk("cont_end_count", int'(count), 3);
        chk("wq_left", wq.size(), 0);
        chk("rq_left", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
